debug_printer: RTL
==================

Name: debug_printer

Overview:
- UART debug message printer; successor to the fixed-length text dumper.
- Sends a variable-length text string, then an optional hex rendering of a binary value, then an optional CR/LF terminator, over one 8N1 serial line.
- Has its own bit-level serializer and a req/busy/done handshake, so any block can print status with one request pulse.

Parameters:
- MAX_LEN, 20: text buffer capacity in characters.
- HEX_DIGITS, 8: number of hex nibbles printed from hex_val.
- CLKS_PER_BIT, 868: clock cycles per UART bit, minimum 2.
- LW, $clog2(MAX_LEN+1): width of text_len (localparam).

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- req, input, 1: print request, sampled on each rising edge.
- busy, output, 1: message in progress; req is ignored while high.
- done, output, 1: one-cycle pulse when a message completes.
- text, input, 8*MAX_LEN: characters; the first character sent is text[8*MAX_LEN-1 -: 8], and order is descending.
- text_len, input, LW: number of characters to send from the top of text.
- hex_en, input, 1: append HEX_DIGITS hex characters of hex_val.
- hex_val, input, 4*HEX_DIGITS: value to print, most significant nibble first.
- crlf_en, input, 1: append 0x0D then 0x0A.
- uart_tx, output, 1: serial output, idle high.

Behaviour:
- Reset (reset==0 at an edge):
  - uart_tx=1, busy=0, done=0.
  - FSM goes to IDLE; all counters clear.
  - This applies mid-frame too. The line returns high at that edge, the message is abandoned, and no done pulse follows.
- Accept:
  - In IDLE with req=1, the block captures text, text_len, hex_en, hex_val and crlf_en into internal registers.
  - Inputs may change freely after the accept edge.
  - busy=1 from the next cycle.
- Clamping: text_len > MAX_LEN is treated as MAX_LEN.
- FSM states: IDLE -> TEXT -> HEX -> CR -> LF -> FIN -> IDLE.
  - Each state is skipped when its count is zero or it is disabled: TEXT if text_len==0, HEX if hex_en==0, CR/LF if crlf_en==0.
- Hex encoding: nibble 0-9 -> 0x30-0x39; nibble 10-15 -> 0x41-0x46 (uppercase).
- Frame format: start bit 0, 8 data bits LSB first, 1 stop bit. Each bit is held exactly CLKS_PER_BIT cycles.
- Character spacing: characters are back-to-back with no idle gap. The next start bit follows directly after the previous stop bit period.
- Latency:
  - The first start bit appears on uart_tx in the cycle after the accept edge.
  - A message of C characters occupies exactly C*10*CLKS_PER_BIT cycles on the line.
  - done=1 in the cycle immediately after the last stop bit period ends; busy=0 in that same cycle.
- Empty message (C==0): accepted normally. uart_tx stays high. busy=0 and done=1 in the cycle after accept.
- Back-to-back messages: req=1 in the done cycle is accepted, since busy is already low. The next start bit follows one cycle after done.
- Requests during busy: req while busy=1 is dropped, not queued, and has no effect on the current message.
- Simultaneous events: reset low wins over req.
- Counters: bit-timer width is $clog2(CLKS_PER_BIT). Character index width is LW. Nibble index width is $clog2(HEX_DIGITS+1). None may wrap during a valid message.

Test Plan (bench uses CLKS_PER_BIT=4, MAX_LEN=4, HEX_DIGITS=2):
- text="ABCD", text_len=2, hex_en=0, crlf_en=0, req pulse:
  - uart_tx decodes to 0x41, 0x42.
  - done pulses exactly 80 cycles after the first start bit; busy high for 80 cycles.
- text_len=0, hex_en=1, hex_val=0x3F, crlf_en=1:
  - line carries 0x33, 0x46, 0x0D, 0x0A in that order.
  - done at 160 cycles.
- text_len=7 (above MAX_LEN=4), text="WXYZ":
  - exactly 4 characters sent: 0x57, 0x58, 0x59, 0x5A.
- All disabled (text_len=0, hex_en=0, crlf_en=0):
  - uart_tx never leaves 1.
  - done=1 and busy=0 one cycle after accept.
- Second req 10 cycles into a message, then req held high through done:
  - the mid-message req is ignored.
  - the second message starts 1 cycle after the done cycle.
- reset=0 for one cycle at cycle 15 of a frame:
  - uart_tx=1, busy=0 from that edge.
  - no done pulse; a following req transmits normally.

Source files
------------

// File: rtl/debug_printer.sv
// debug_printer: prints a text string, an optional hex value and an optional
// CR/LF terminator as back-to-back 8N1 UART characters, using a req/busy/done handshake.
module debug_printer #(
  parameter int MAX_LEN      = 20,
  parameter int HEX_DIGITS   = 8,
  parameter int CLKS_PER_BIT = 868,
  localparam int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  output logic                    busy,
  output logic                    done,
  input  logic [8*MAX_LEN-1:0]    text,
  input  logic [LW-1:0]           text_len,
  input  logic                    hex_en,
  input  logic [4*HEX_DIGITS-1:0] hex_val,
  input  logic                    crlf_en,
  output logic                    uart_tx
);

  localparam int NW = $clog2(HEX_DIGITS + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_LEN);
  localparam logic [NW-1:0] NIB_COUNT  = NW'(HEX_DIGITS);
  localparam logic [3:0]    BIT_STOP   = 4'd9;
  localparam logic [3:0]    BIT_LAST_D = 4'd8;

  // The state names the message segment whose character is currently on the line.
  // FIN is the one-cycle done state; it accepts a new request just like IDLE.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TEXT,
    ST_HEX,
    ST_CR,
    ST_LF,
    ST_FIN
  } state_t;

  // First segment that actually has a character to send, or FIN if none.
  function automatic state_t first_seg(input logic [LW-1:0] len,
                                       input logic hx,
                                       input logic cl);
    state_t s;
    if (len != '0)  s = ST_TEXT;
    else if (hx)    s = ST_HEX;
    else if (cl)    s = ST_CR;
    else            s = ST_FIN;
    return s;
  endfunction

  // ASCII code for a given segment/position.
  function automatic logic [7:0] char_of(input state_t seg,
                                         input logic [LW-1:0] ci,
                                         input logic [NW-1:0] ni,
                                         input logic [8*MAX_LEN-1:0] txt,
                                         input logic [4*HEX_DIGITS-1:0] hv);
    logic [3:0] nib;
    logic [7:0] ch;
    nib = hv[4*HEX_DIGITS-1 - 4*int'(ni) -: 4];
    ch  = 8'h00;
    case (seg)
      ST_TEXT: ch = txt[8*MAX_LEN-1 - 8*int'(ci) -: 8];
      ST_HEX:  ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      ST_CR:   ch = 8'h0D;
      ST_LF:   ch = 8'h0A;
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  state_t                  state_q,    state_d;
  logic [LW-1:0]           char_idx_q, char_idx_d;
  logic [NW-1:0]           nib_idx_q,  nib_idx_d;
  logic [3:0]              bit_cnt_q,  bit_cnt_d;
  logic [TW-1:0]           timer_q,    timer_d;
  logic [7:0]              char_q,     char_d;
  logic [8*MAX_LEN-1:0]    text_q,     text_d;
  logic [LW-1:0]           len_q,      len_d;
  logic                    hex_en_q,   hex_en_d;
  logic [4*HEX_DIGITS-1:0] hex_val_q,  hex_val_d;
  logic                    crlf_q,     crlf_d;
  logic                    tx_q,       tx_d;
  logic                    busy_q,     busy_d;
  logic                    done_q,     done_d;

  logic [LW-1:0] len_clamp;
  state_t        acc_state;
  logic [7:0]    acc_char;
  state_t        adv_state;
  logic [LW-1:0] adv_ci;
  logic [NW-1:0] adv_ni;
  logic [7:0]    adv_char;

  // Lengths beyond the buffer are limited to the buffer size.
  assign len_clamp = (text_len > LEN_MAX) ? LEN_MAX : text_len;

  // The first character is derived from the live inputs so its start bit can go out right after accept.
  always_comb begin
    acc_state = first_seg(len_clamp, hex_en, crlf_en);
    acc_char  = char_of(acc_state, '0, '0, text, hex_val);
  end

  // Pick the character that follows the one currently on the line, skipping empty segments.
  always_comb begin
    adv_state = ST_FIN;
    adv_ci    = '0;
    adv_ni    = '0;
    case (state_q)
      ST_TEXT: begin
        if (char_idx_q + LW'(1) < len_q) begin
          adv_state = ST_TEXT;
          adv_ci    = char_idx_q + LW'(1);
        end else if (hex_en_q) begin
          adv_state = ST_HEX;
        end else if (crlf_q) begin
          adv_state = ST_CR;
        end
      end
      ST_HEX: begin
        if (nib_idx_q + NW'(1) < NIB_COUNT) begin
          adv_state = ST_HEX;
          adv_ni    = nib_idx_q + NW'(1);
        end else if (crlf_q) begin
          adv_state = ST_CR;
        end
      end
      ST_CR:   adv_state = ST_LF;
      default: adv_state = ST_FIN;
    endcase
    adv_char = char_of(adv_state, adv_ci, adv_ni, text_q, hex_val_q);
  end

  // Next-state logic: accept in IDLE/FIN, then bit timing and character sequencing.
  always_comb begin
    state_d    = state_q;
    char_idx_d = char_idx_q;
    nib_idx_d  = nib_idx_q;
    bit_cnt_d  = bit_cnt_q;
    timer_d    = timer_q;
    char_d     = char_q;
    text_d     = text_q;
    len_d      = len_q;
    hex_en_d   = hex_en_q;
    hex_val_d  = hex_val_q;
    crlf_d     = crlf_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        if (req) begin
          text_d     = text;
          len_d      = len_clamp;
          hex_en_d   = hex_en;
          hex_val_d  = hex_val;
          crlf_d     = crlf_en;
          char_idx_d = '0;
          nib_idx_d  = '0;
          bit_cnt_d  = '0;
          timer_d    = '0;
          if (acc_state == ST_FIN) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = acc_state;
            char_d  = acc_char;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      default: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (bit_cnt_q == BIT_STOP) begin
            bit_cnt_d = '0;
            if (adv_state == ST_FIN) begin
              state_d = ST_FIN;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d    = adv_state;
              char_idx_d = adv_ci;
              nib_idx_d  = adv_ni;
              char_d     = adv_char;
              tx_d       = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = (bit_cnt_q == BIT_LAST_D) ? 1'b1 : char_q[bit_cnt_q[2:0]];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any message in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      char_idx_q <= '0;
      nib_idx_q  <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      char_q     <= '0;
      text_q     <= '0;
      len_q      <= '0;
      hex_en_q   <= 1'b0;
      hex_val_q  <= '0;
      crlf_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_idx_q <= char_idx_d;
      nib_idx_q  <= nib_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      char_q     <= char_d;
      text_q     <= text_d;
      len_q      <= len_d;
      hex_en_q   <= hex_en_d;
      hex_val_q  <= hex_val_d;
      crlf_q     <= crlf_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
